picorv32_axi_bridge: RTL and testbench

//  Memory-interface front end of picorv32_axi. Converts the core's native single-outstanding request

---
 rtl/picorv32_axi_bridge.sv | 96 +++++++++
 tb/tb_picorv32_axi_bridge.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/picorv32_axi_bridge.sv
// picorv32_axi_bridge: native mem_valid/mem_ready port to AXI4-Lite master, one transaction at a time.
// Define PICORV32_AXI_ACK_REG_EN to register the mem_ready/mem_rdata return path (+1 cycle latency).
module picorv32_axi_bridge #(
    parameter int         ADDR_W    = 32,
    parameter logic [2:0] INSN_PROT = 3'b100
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              mem_valid,
    input  logic              mem_instr,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_wdata,
    input  logic [3:0]        mem_wstrb,
    output logic              mem_ready,
    output logic [31:0]       mem_rdata,
    output logic              mem_axi_awvalid,
    input  logic              mem_axi_awready,
    output logic [ADDR_W-1:0] mem_axi_awaddr,
    output logic [2:0]        mem_axi_awprot,
    output logic              mem_axi_wvalid,
    input  logic              mem_axi_wready,
    output logic [31:0]       mem_axi_wdata,
    output logic [3:0]        mem_axi_wstrb,
    input  logic              mem_axi_bvalid,
    output logic              mem_axi_bready,
    output logic              mem_axi_arvalid,
    input  logic              mem_axi_arready,
    output logic [ADDR_W-1:0] mem_axi_araddr,
    output logic [2:0]        mem_axi_arprot,
    input  logic              mem_axi_rvalid,
    output logic              mem_axi_rready,
    input  logic [31:0]       mem_axi_rdata
);
    logic r_ack_aw, r_ack_w, r_ack_ar, r_xfer_done;
    logic w_is_wr, w_aw_hs, w_w_hs, w_ar_hs, w_b_hs, w_r_hs;

    assign w_is_wr         = |mem_wstrb;
    assign mem_axi_awvalid = mem_valid & w_is_wr & !r_ack_aw;
    assign mem_axi_wvalid  = mem_valid & w_is_wr & !r_ack_w;
    assign mem_axi_arvalid = mem_valid & !w_is_wr & !r_ack_ar;
    assign mem_axi_awaddr  = mem_addr;
    assign mem_axi_araddr  = mem_addr;
    assign mem_axi_wdata   = mem_wdata;
    assign mem_axi_wstrb   = mem_wstrb;
    assign mem_axi_awprot  = 3'b000;
    assign mem_axi_arprot  = mem_instr ? INSN_PROT : 3'b000;

    assign w_aw_hs = mem_axi_awvalid & mem_axi_awready;
    assign w_w_hs  = mem_axi_wvalid & mem_axi_wready;
    assign w_ar_hs = mem_axi_arvalid & mem_axi_arready;
    assign w_b_hs  = mem_axi_bvalid & mem_axi_bready;
    assign w_r_hs  = mem_axi_rvalid & mem_axi_rready;

    // A handshake of the next request landing in the clear cycle must survive the clear.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_ack_aw    <= 1'b0;
            r_ack_w     <= 1'b0;
            r_ack_ar    <= 1'b0;
            r_xfer_done <= 1'b0;
        end else begin
            r_ack_aw    <= (r_ack_aw & !r_xfer_done) | w_aw_hs;
            r_ack_w     <= (r_ack_w & !r_xfer_done) | w_w_hs;
            r_ack_ar    <= (r_ack_ar & !r_xfer_done) | w_ar_hs;
            r_xfer_done <= mem_valid & mem_ready;
        end
    end

`ifdef PICORV32_AXI_ACK_REG_EN
    logic        r_resp, r_ready;
    logic [31:0] r_rdata;

    assign mem_axi_bready = mem_valid & w_is_wr & !r_resp;
    assign mem_axi_rready = mem_valid & !w_is_wr & !r_resp;
    assign mem_ready      = r_ready;
    assign mem_rdata      = r_rdata;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_resp  <= 1'b0;
            r_ready <= 1'b0;
            r_rdata <= 32'h0;
        end else begin
            r_resp  <= (r_resp & !r_xfer_done) | w_b_hs | w_r_hs;
            r_ready <= w_b_hs | w_r_hs;
            if (w_r_hs)
                r_rdata <= mem_axi_rdata;
        end
    end
`else
    assign mem_axi_bready = mem_valid & w_is_wr;
    assign mem_axi_rready = mem_valid & !w_is_wr;
    assign mem_ready      = w_b_hs | w_r_hs;
    assign mem_rdata      = mem_axi_rdata;
`endif
endmodule

// File: tb/tb_picorv32_axi_bridge.sv
// tb_picorv32_axi_bridge: directed scenarios plus a randomized slave checked against a reference memory.
module tb_picorv32_axi_bridge;
    logic        clk = 1'b0, resetn = 1'b0;
    logic        mem_valid = 1'b0, mem_instr = 1'b0;
    logic [31:0] mem_addr = '0, mem_wdata = '0;
    logic [3:0]  mem_wstrb = '0;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        mem_axi_awvalid, mem_axi_awready = 1'b0;
    logic [31:0] mem_axi_awaddr;
    logic [2:0]  mem_axi_awprot;
    logic        mem_axi_wvalid, mem_axi_wready = 1'b0;
    logic [31:0] mem_axi_wdata;
    logic [3:0]  mem_axi_wstrb;
    logic        mem_axi_bvalid = 1'b0, mem_axi_bready;
    logic        mem_axi_arvalid, mem_axi_arready = 1'b0;
    logic [31:0] mem_axi_araddr;
    logic [2:0]  mem_axi_arprot;
    logic        mem_axi_rvalid = 1'b0, mem_axi_rready;
    logic [31:0] mem_axi_rdata = '0;

    int n_cmp = 0, n_err = 0;

    picorv32_axi_bridge dut (
        .clk(clk), .resetn(resetn),
        .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .mem_axi_awvalid(mem_axi_awvalid), .mem_axi_awready(mem_axi_awready),
        .mem_axi_awaddr(mem_axi_awaddr), .mem_axi_awprot(mem_axi_awprot),
        .mem_axi_wvalid(mem_axi_wvalid), .mem_axi_wready(mem_axi_wready),
        .mem_axi_wdata(mem_axi_wdata), .mem_axi_wstrb(mem_axi_wstrb),
        .mem_axi_bvalid(mem_axi_bvalid), .mem_axi_bready(mem_axi_bready),
        .mem_axi_arvalid(mem_axi_arvalid), .mem_axi_arready(mem_axi_arready),
        .mem_axi_araddr(mem_axi_araddr), .mem_axi_arprot(mem_axi_arprot),
        .mem_axi_rvalid(mem_axi_rvalid), .mem_axi_rready(mem_axi_rready), .mem_axi_rdata(mem_axi_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Reference memory: unwritten words hold a fixed address-derived pattern.
    logic [31:0] refmem [logic [31:0]];
    logic [31:0] smem   [logic [31:0]];

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++)
            if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) cyc();
        n_cmp++;
        if ({mem_axi_awvalid, mem_axi_wvalid, mem_axi_arvalid, mem_ready} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_valids: aw/w/ar/ready=%b%b%b%b want 0000", mem_axi_awvalid, mem_axi_wvalid, mem_axi_arvalid, mem_ready);
        end
        n_cmp++;
        if ({mem_axi_bready, mem_axi_rready} !== 2'b00) begin
            n_err++;
            $display("FAIL reset_readies: b/r=%b%b want 00", mem_axi_bready, mem_axi_rready);
        end
        cyc();
        resetn = 1'b1;
        cyc();
        n_cmp++;
        if ({mem_axi_awvalid, mem_axi_wvalid, mem_axi_arvalid, mem_ready} !== 4'b0000) begin
            n_err++;
            $display("FAIL post_reset_idle: aw/w/ar/ready=%b%b%b%b want 0000", mem_axi_awvalid, mem_axi_wvalid, mem_axi_arvalid, mem_ready);
        end
    endtask

    task automatic test_read_zero_wait();
        cyc();
        mem_valid = 1'b1; mem_instr = 1'b1; mem_addr = 32'h100; mem_wstrb = 4'h0; mem_axi_arready = 1'b1;
        #1;
        n_cmp++;
        if (mem_axi_arvalid !== 1'b1 || mem_axi_arprot !== 3'b100 || mem_axi_araddr !== 32'h100) begin
            n_err++;
            $display("FAIL rd_ar: arvalid=%b arprot=%b araddr=%h want 1 100 00000100", mem_axi_arvalid, mem_axi_arprot, mem_axi_araddr);
        end
        n_cmp++;
        if (mem_ready !== 1'b0 || mem_axi_rready !== 1'b1 || mem_axi_awvalid !== 1'b0) begin
            n_err++;
            $display("FAIL rd_start: ready=%b rready=%b awvalid=%b want 0 1 0", mem_ready, mem_axi_rready, mem_axi_awvalid);
        end
        cyc();
        mem_axi_arready = 1'b0; mem_axi_rvalid = 1'b1; mem_axi_rdata = 32'hDEADBEEF;
        #1;
        n_cmp++;
        if (mem_ready !== 1'b1 || mem_rdata !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL rd_data: ready=%b rdata=%h want 1 deadbeef", mem_ready, mem_rdata);
        end
        n_cmp++;
        if (mem_axi_arvalid !== 1'b0) begin
            n_err++;
            $display("FAIL rd_no_reissue: arvalid=%b want 0", mem_axi_arvalid);
        end
        cyc();
        mem_valid = 1'b0; mem_instr = 1'b0; mem_axi_rvalid = 1'b0;
        #1;
        n_cmp++;
        if (mem_ready !== 1'b0) begin
            n_err++;
            $display("FAIL rd_ready_pulse: ready=%b want 0", mem_ready);
        end
        repeat (2) cyc();
    endtask

    task automatic test_write_aw_first();
        cyc();
        mem_valid = 1'b1; mem_addr = 32'h1000_0000; mem_wdata = 32'h41; mem_wstrb = 4'b0001; mem_axi_awready = 1'b1;
        #1;
        n_cmp++;
        if (mem_axi_awvalid !== 1'b1 || mem_axi_wvalid !== 1'b1 || mem_axi_awaddr !== 32'h1000_0000 || mem_axi_awprot !== 3'b000) begin
            n_err++;
            $display("FAIL wr_aw: awvalid=%b wvalid=%b awaddr=%h awprot=%b want 1 1 10000000 000", mem_axi_awvalid, mem_axi_wvalid, mem_axi_awaddr, mem_axi_awprot);
        end
        n_cmp++;
        if (mem_axi_bready !== 1'b1 || mem_ready !== 1'b0 || mem_axi_arvalid !== 1'b0) begin
            n_err++;
            $display("FAIL wr_start: bready=%b ready=%b arvalid=%b want 1 0 0", mem_axi_bready, mem_ready, mem_axi_arvalid);
        end
        for (int k = 1; k <= 3; k++) begin
            cyc();
            mem_axi_awready = 1'b0; mem_axi_wready = (k == 3);
            #1;
            n_cmp++;
            if (mem_axi_awvalid !== 1'b0 || mem_axi_wvalid !== 1'b1 || mem_ready !== 1'b0) begin
                n_err++;
                $display("FAIL wr_w_wait%0d: awvalid=%b wvalid=%b ready=%b want 0 1 0", k, mem_axi_awvalid, mem_axi_wvalid, mem_ready);
            end
        end
        n_cmp++;
        if (mem_axi_wdata !== 32'h41 || mem_axi_wstrb !== 4'b0001) begin
            n_err++;
            $display("FAIL wr_wdata: wdata=%h wstrb=%b want 00000041 0001", mem_axi_wdata, mem_axi_wstrb);
        end
        cyc();
        mem_axi_wready = 1'b0; mem_axi_bvalid = 1'b1;
        #1;
        n_cmp++;
        if (mem_axi_awvalid !== 1'b0 || mem_axi_wvalid !== 1'b0 || mem_ready !== 1'b1) begin
            n_err++;
            $display("FAIL wr_b: awvalid=%b wvalid=%b ready=%b want 0 0 1", mem_axi_awvalid, mem_axi_wvalid, mem_ready);
        end
        cyc();
        mem_valid = 1'b0; mem_wstrb = 4'h0; mem_axi_bvalid = 1'b0;
        repeat (2) cyc();
    endtask

    task automatic test_write_w_first();
        int na = 0, nw = 0, nr = 0, rc = -1;
        for (int c = 0; c < 10; c++) begin
            cyc();
            if (c == 0) begin
                mem_valid = 1'b1; mem_addr = 32'h40; mem_wdata = 32'hCAFEF00D; mem_wstrb = 4'hF;
            end
            if (c == 8) begin
                mem_valid = 1'b0; mem_wstrb = 4'h0;
            end
            mem_axi_wready = (c == 0); mem_axi_awready = (c == 2); mem_axi_bvalid = (c == 7);
            #1;
            na += int'(mem_axi_awvalid & mem_axi_awready);
            nw += int'(mem_axi_wvalid & mem_axi_wready);
            if (mem_ready) begin
                nr++;
                rc = c;
            end
        end
        mem_axi_bvalid = 1'b0;
        n_cmp++;
        if (na != 1 || nw != 1) begin
            n_err++;
            $display("FAIL wfirst_handshakes: aw=%0d w=%0d want 1 1", na, nw);
        end
        n_cmp++;
        if (nr != 1 || rc != 7) begin
            n_err++;
            $display("FAIL wfirst_ready: pulses=%0d at cycle %0d want 1 at 7", nr, rc);
        end
        repeat (2) cyc();
    endtask

    task automatic test_back_to_back();
        cyc();
        mem_valid = 1'b1; mem_addr = 32'h200; mem_wstrb = 4'h0; mem_axi_arready = 1'b1;
        cyc();
        mem_axi_arready = 1'b0; mem_axi_rvalid = 1'b1; mem_axi_rdata = 32'h11;
        #1;
        n_cmp++;
        if (mem_ready !== 1'b1 || mem_rdata !== 32'h11) begin
            n_err++;
            $display("FAIL b2b_read: ready=%b rdata=%h want 1 00000011", mem_ready, mem_rdata);
        end
        cyc();
        mem_axi_rvalid = 1'b0; mem_addr = 32'h2000_0000; mem_wdata = 123456789; mem_wstrb = 4'hF;
        mem_axi_awready = 1'b1; mem_axi_wready = 1'b1;
        #1;
        n_cmp++;
        if (mem_axi_awvalid !== 1'b1 || mem_axi_wvalid !== 1'b1 || mem_axi_arvalid !== 1'b0 || mem_ready !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_issue: aw=%b w=%b ar=%b ready=%b want 1 1 0 0", mem_axi_awvalid, mem_axi_wvalid, mem_axi_arvalid, mem_ready);
        end
        n_cmp++;
        if (mem_axi_wdata !== 32'h075BCD15 || mem_axi_awaddr !== 32'h2000_0000) begin
            n_err++;
            $display("FAIL b2b_wdata: wdata=%h awaddr=%h want 075bcd15 20000000", mem_axi_wdata, mem_axi_awaddr);
        end
        cyc();
        mem_axi_awready = 1'b0; mem_axi_wready = 1'b0; mem_axi_bvalid = 1'b1;
        #1;
        n_cmp++;
        if (mem_axi_awvalid !== 1'b0 || mem_axi_wvalid !== 1'b0 || mem_ready !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_write_done: aw=%b w=%b ready=%b want 0 0 1", mem_axi_awvalid, mem_axi_wvalid, mem_ready);
        end
        cyc();
        mem_valid = 1'b0; mem_wstrb = 4'h0; mem_axi_bvalid = 1'b0;
        repeat (2) cyc();
    endtask

    task automatic test_reset_mid();
        int stray = 0;
        cyc();
        mem_valid = 1'b1; mem_addr = 32'h300; mem_wstrb = 4'h0; mem_instr = 1'b0;
        cyc();
        mem_axi_arready = 1'b1;
        cyc();
        mem_axi_arready = 1'b0; resetn = 1'b0; mem_valid = 1'b0; mem_axi_rvalid = 1'b1; mem_axi_rdata = 32'h99;
        for (int k = 0; k < 3; k++) begin
            #1;
            stray += int'(mem_ready);
            cyc();
        end
        n_cmp++;
        if (stray != 0) begin
            n_err++;
            $display("FAIL rst_stray_ready: pulses=%0d want 0", stray);
        end
        resetn = 1'b1; mem_axi_rvalid = 1'b0; mem_valid = 1'b1;
        #1;
        n_cmp++;
        if (mem_axi_arvalid !== 1'b1 || mem_axi_rready !== 1'b1 || mem_ready !== 1'b0) begin
            n_err++;
            $display("FAIL rst_flags_cleared: arvalid=%b rready=%b ready=%b want 1 1 0", mem_axi_arvalid, mem_axi_rready, mem_ready);
        end
        cyc();
        mem_axi_arready = 1'b1;
        cyc();
        mem_axi_arready = 1'b0; mem_axi_rvalid = 1'b1; mem_axi_rdata = 32'h55;
        #1;
        n_cmp++;
        if (mem_ready !== 1'b1 || mem_rdata !== 32'h55) begin
            n_err++;
            $display("FAIL rst_recover: ready=%b rdata=%h want 1 00000055", mem_ready, mem_rdata);
        end
        cyc();
        mem_valid = 1'b0; mem_axi_rvalid = 1'b0;
        repeat (2) cyc();
    endtask

    // Randomized slave state and the request currently presented.
    bit          s_aw, s_w, s_ar;
    logic [31:0] s_awaddr, s_wdata, s_araddr;
    logic [3:0]  s_wstrb;
    int          b_cnt = -1, r_cnt = -1, n_aw, n_w, n_ar, n_dup;
    bit          cur_wr, cur_instr;
    logic [31:0] cur_addr, cur_wdata;
    logic [3:0]  cur_wstrb;

    task automatic rnd_cycle(output bit done);
        logic exp_ready;
        mem_axi_awready = !s_aw && $urandom_range(0, 1);
        mem_axi_wready  = !s_w && $urandom_range(0, 1);
        mem_axi_arready = !s_ar && $urandom_range(0, 1);
        mem_axi_bvalid  = s_aw && s_w && b_cnt == 0;
        mem_axi_rvalid  = s_ar && r_cnt == 0;
        mem_axi_rdata   = mem_axi_rvalid ? (smem.exists(s_araddr) ? smem[s_araddr] : init_word(s_araddr)) : $urandom;
        #1;
        n_dup += int'(mem_axi_awvalid && s_aw) + int'(mem_axi_wvalid && s_w) + int'(mem_axi_arvalid && s_ar);
        if (!mem_valid) n_dup += int'(mem_axi_awvalid | mem_axi_wvalid | mem_axi_arvalid);
        if (mem_axi_awvalid && mem_axi_awready) begin
            n_aw++; s_aw = 1'b1; s_awaddr = mem_axi_awaddr;
            n_cmp++;
            if (mem_axi_awaddr !== cur_addr || mem_axi_awprot !== 3'b000) begin
                n_err++;
                $display("FAIL rnd_aw: awaddr=%h awprot=%b want %h 000", mem_axi_awaddr, mem_axi_awprot, cur_addr);
            end
        end
        if (mem_axi_wvalid && mem_axi_wready) begin
            n_w++; s_w = 1'b1; s_wdata = mem_axi_wdata; s_wstrb = mem_axi_wstrb;
            n_cmp++;
            if (mem_axi_wdata !== cur_wdata || mem_axi_wstrb !== cur_wstrb) begin
                n_err++;
                $display("FAIL rnd_w: wdata=%h wstrb=%b want %h %b", mem_axi_wdata, mem_axi_wstrb, cur_wdata, cur_wstrb);
            end
        end
        if (mem_axi_arvalid && mem_axi_arready) begin
            n_ar++; s_ar = 1'b1; s_araddr = mem_axi_araddr;
            n_cmp++;
            if (mem_axi_araddr !== cur_addr || mem_axi_arprot !== (cur_instr ? 3'b100 : 3'b000)) begin
                n_err++;
                $display("FAIL rnd_ar: araddr=%h arprot=%b want %h instr=%b", mem_axi_araddr, mem_axi_arprot, cur_addr, cur_instr);
            end
        end
        exp_ready = mem_axi_bvalid | mem_axi_rvalid;
        if (mem_ready !== exp_ready) begin
            n_cmp++; n_err++;
            $display("FAIL rnd_ready: ready=%b want %b", mem_ready, exp_ready);
        end
        if (mem_axi_bvalid && mem_axi_bready) begin
            smem[s_awaddr] = merge(smem.exists(s_awaddr) ? smem[s_awaddr] : init_word(s_awaddr), s_wdata, s_wstrb);
            s_aw = 1'b0; s_w = 1'b0; b_cnt = -1;
        end
        if (mem_axi_rvalid && mem_axi_rready) begin
            s_ar = 1'b0; r_cnt = -1;
        end
        if (b_cnt > 0) b_cnt--;
        if (r_cnt > 0) r_cnt--;
        if (s_aw && s_w && b_cnt < 0) b_cnt = $urandom_range(0, 3);
        if (s_ar && r_cnt < 0) r_cnt = $urandom_range(0, 3);
        done = mem_ready;
    endtask

    task automatic test_random(input int n);
        bit done, abort = 1'b0;
        logic [31:0] exp;
        for (int t = 0; t < n && !abort; t++) begin
            repeat ($urandom_range(0, 2)) begin
                cyc();
                mem_valid = 1'b0;
                rnd_cycle(done);
            end
            cur_wr    = $urandom_range(0, 1);
            cur_addr  = 32'h8000_0000 + {$urandom_range(0, 15), 2'b00};
            cur_wdata = $urandom;
            cur_wstrb = cur_wr ? 4'($urandom_range(1, 15)) : 4'h0;
            cur_instr = !cur_wr && $urandom_range(0, 1);
            n_aw = 0; n_w = 0; n_ar = 0; n_dup = 0; done = 1'b0;
            for (int k = 0; k < 200 && !done; k++) begin
                cyc();
                if (k == 0) begin
                    mem_valid = 1'b1; mem_addr = cur_addr; mem_wdata = cur_wdata;
                    mem_wstrb = cur_wstrb; mem_instr = cur_instr;
                end
                rnd_cycle(done);
            end
            n_cmp++;
            if (!done) begin
                n_err++; abort = 1'b1;
                $display("FAIL rnd_timeout: transaction %0d never completed", t);
            end else if (n_aw != int'(cur_wr) || n_w != int'(cur_wr) || n_ar != int'(!cur_wr) || n_dup != 0) begin
                n_err++;
                $display("FAIL rnd_handshakes: txn %0d aw=%0d w=%0d ar=%0d dup=%0d want %0d %0d %0d 0", t, n_aw, n_w, n_ar, n_dup, cur_wr, cur_wr, !cur_wr);
            end
            exp = refmem.exists(cur_addr) ? refmem[cur_addr] : init_word(cur_addr);
            if (cur_wr) refmem[cur_addr] = merge(exp, cur_wdata, cur_wstrb);
            else begin
                n_cmp++;
                if (mem_rdata !== exp) begin
                    n_err++;
                    $display("FAIL rnd_rdata: txn %0d addr=%h rdata=%h want %h", t, cur_addr, mem_rdata, exp);
                end
            end
        end
        cyc();
        mem_valid = 1'b0; mem_wstrb = 4'h0;
        mem_axi_awready = 1'b0; mem_axi_wready = 1'b0; mem_axi_arready = 1'b0;
        mem_axi_bvalid = 1'b0; mem_axi_rvalid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_read_zero_wait();
        test_write_aw_first();
        test_write_w_first();
        test_back_to_back();
        test_reset_mid();
        test_random(4000);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
